// File: rtl/accelbrot_com_pkg.sv
// Shared types and helpers for the arithmetic-unit arbiter.
package accelbrot_com_pkg;

  // Widest requester vector the round-robin helper handles.
  localparam int unsigned RR_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Tag width for n requesters: clog2(n), never below one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // One-hot pick of the first set candidate after position 'last', wrapping mod n.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] cand,
                                                input int unsigned      last,
                                                input int unsigned      n);
    logic [RR_MAX-1:0] pick;
    int unsigned       idx;
    pick = '0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = (last + k) % n;
      if (pick == '0 && cand[idx[2:0]]) pick[idx[2:0]] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/accelbrot_com_tag_fifo.sv
// Tag FIFO: records which requester owns each operand in flight.
module accelbrot_com_tag_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Push into a full FIFO is only honoured when a pop frees a slot the same cycle.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/accelbrot_com_arb.sv
// Round-robin arbiter sharing one word-serial arithmetic unit between NREQ requesters.
module accelbrot_com_arb
  import accelbrot_com_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned NWORDS  = 8,
  parameter int unsigned WWIDTH  = 34,
  parameter int unsigned MAXINFL = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [WWIDTH-1:0]      unit_in,
  output logic                   unit_in_start,
  output logic                   unit_in_valid,
  input  logic [WWIDTH-1:0]      unit_out,
  input  logic                   unit_out_start,
  input  logic                   unit_out_valid,
  output logic [WWIDTH-1:0]      resp_data,
  output logic                   resp_start,
  output logic [NREQ-1:0]        resp_valid,
  output logic                   err
);

  localparam int unsigned TW = tag_width(NREQ);
  localparam int unsigned CW = $clog2(NWORDS);
  localparam int unsigned FW = $clog2(MAXINFL + 1);

  arb_state_t        state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [TW-1:0]     ptr, ptr_nx, win_idx, cur_tag, tag_use, fifo_dout;
  logic [NREQ-1:0]   gnt_nx, cand, pick;
  logic [FW-1:0]     fifo_count, occ_after;
  logic [WWIDTH-1:0] word_sel;
  logic              last_word, arb_en, win, push, pop, start_in;
  logic              fifo_empty, fifo_full, cur_ok, ok_use;

  // Round-robin search; the slot owner is excluded at its last word so others rotate in.
  always_comb begin
    last_word = (state == BUSY) && (cnt == CW'(NWORDS - 1));
    arb_en    = (state == IDLE) || last_word;
    cand      = req & ~(last_word ? gnt : '0);
    pick      = NREQ'(rr_pick(RR_MAX'(cand), 32'(ptr), NREQ));
    occ_after = fifo_count - FW'(pop);
    win       = arb_en && (pick != '0) && (occ_after < FW'(MAXINFL));
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) win_idx = TW'(i);
    end
  end

  // Next-state: a win at the arbitration cycle starts a slot back-to-back.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    ptr_nx   = ptr;
    push     = 1'b0;
    if (arb_en) begin
      cnt_nx = '0;
      if (win) begin
        state_nx = BUSY;
        gnt_nx   = pick;
        ptr_nx   = win_idx;
        push     = 1'b1;
      end else begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    end else begin
      cnt_nx = cnt + 1'b1;
    end
  end

  // Select the granted requester's current word.
  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) word_sel = req_data[i*WWIDTH +: WWIDTH];
    end
  end

  // FSM, grant and unit-input registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= TW'(NREQ - 1);
      gnt           <= '0;
      unit_in       <= '0;
      unit_in_start <= 1'b0;
      unit_in_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      ptr           <= ptr_nx;
      gnt           <= gnt_nx;
      unit_in       <= word_sel;
      unit_in_start <= (|gnt) && (cnt == '0);
      unit_in_valid <= |gnt;
    end
  end

  // A start word takes the FIFO head; continuation words reuse the latched tag.
  always_comb begin
    start_in = unit_out_valid && unit_out_start;
    pop      = start_in && !fifo_empty;
    tag_use  = start_in ? fifo_dout : cur_tag;
    ok_use   = start_in ? !fifo_empty : cur_ok;
  end

  // Result steering and sticky error.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_data  <= '0;
      resp_start <= 1'b0;
      resp_valid <= '0;
      cur_tag    <= '0;
      cur_ok     <= 1'b0;
      err        <= 1'b0;
    end else begin
      resp_data  <= unit_out;
      resp_start <= unit_out_start;
      resp_valid <= (unit_out_valid && ok_use) ? (NREQ'(1) << tag_use) : '0;
      if (start_in) begin
        cur_tag <= fifo_dout;
        cur_ok  <= !fifo_empty;
      end
      if ((start_in && fifo_empty) || (push && fifo_full && !pop)) err <= 1'b1;
    end
  end

  // The grant guard keeps the tag FIFO from ever being pushed while full.
  always_ff @(posedge clk) begin
    if (rstn) assert (!(push && fifo_full && !pop));
  end

  accelbrot_com_tag_fifo #(
    .DEPTH (MAXINFL),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (win_idx),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_accelbrot_com_arb.sv
// Directed bench: arbitration table with loopback unit, then stall, error and reset sequences.
module tb_accelbrot_com_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NW   = 8;
  localparam int unsigned W    = 34;
  localparam int unsigned MI   = 2;
  localparam int unsigned LAT  = 8;
  localparam int unsigned NT   = 17;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      unit_in;
  logic              unit_in_start, unit_in_valid;
  logic [W-1:0]      unit_out;
  logic              unit_out_start, unit_out_valid;
  logic [W-1:0]      resp_data;
  logic              resp_start;
  logic [NREQ-1:0]   resp_valid;
  logic              err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  accelbrot_com_arb #(
    .NREQ    (NREQ),
    .NWORDS  (NW),
    .WWIDTH  (W),
    .MAXINFL (MI)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .unit_in        (unit_in),
    .unit_in_start  (unit_in_start),
    .unit_in_valid  (unit_in_valid),
    .unit_out       (unit_out),
    .unit_out_start (unit_out_start),
    .unit_out_valid (unit_out_valid),
    .resp_data      (resp_data),
    .resp_start     (resp_start),
    .resp_valid     (resp_valid),
    .err            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] wordval(input int unsigned i, input int unsigned op,
                                           input int unsigned k);
    logic [W-1:0] v;
    v = W'(i) << 30;
    v = v | (W'(op & 255) << 20);
    v = v | (W'(k & 15) << 16);
    v = v | W'((i * 7919 + op * 104 + k * 13) & 32'hFFFF);
    v[33] = k[0] ^ i[0];
    return v;
  endfunction

  function automatic int unsigned oh2idx(input logic [NREQ-1:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester model: word k of operand op on its k-th grant cycle.
  int unsigned rk  [NREQ];
  int unsigned rop [NREQ];
  always @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!rstn) begin
        rk[i]  <= 0;
        rop[i] <= 0;
      end else if (gnt[i]) begin
        if (rk[i] == NW - 1) begin
          rk[i]  <= 0;
          rop[i] <= rop[i] + 1;
        end else begin
          rk[i] <= rk[i] + 1;
        end
      end
    end
  end

  always_comb begin
    req_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) req_data[i*W +: W] = wordval(i, rop[i], rk[i]);
  end

  // Shared-unit model: LAT-cycle loopback, or manually driven results.
  logic         loop_en;
  logic [W-1:0] man_data;
  logic         man_start, man_valid;
  logic [W-1:0] dl_d [LAT];
  logic         dl_s [LAT];
  logic         dl_v [LAT];
  always @(posedge clk) begin
    for (int unsigned i = 0; i < LAT; i++) begin
      if (!rstn) begin
        dl_d[i] <= '0;
        dl_s[i] <= 1'b0;
        dl_v[i] <= 1'b0;
      end else if (i == 0) begin
        dl_d[0] <= unit_in;
        dl_s[0] <= unit_in_start;
        dl_v[0] <= unit_in_valid;
      end else begin
        dl_d[i] <= dl_d[i-1];
        dl_s[i] <= dl_s[i-1];
        dl_v[i] <= dl_v[i-1];
      end
    end
  end
  always_comb begin
    unit_out       = loop_en ? dl_d[LAT-1] : man_data;
    unit_out_start = loop_en ? dl_s[LAT-1] : man_start;
    unit_out_valid = loop_en ? dl_v[LAT-1] : man_valid;
  end

  // Response scoreboard: each expected operand is (requester, operand index).
  typedef struct {
    int unsigned w;
    int unsigned op;
  } sb_t;
  sb_t         sbq[$];
  sb_t         cur;
  logic        mon_en = 1'b0;
  logic        cur_ok = 1'b0;
  int unsigned rsp_k = 0;
  int unsigned rsp_ops = 0;
  int unsigned granted = 0;

  always @(negedge clk) begin
    if (mon_en && rstn && resp_valid != '0) begin
      if (resp_start) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got resp_valid %0h expected no result", resp_valid);
          cur_ok = 1'b0;
        end else begin
          cur    = sbq.pop_front();
          cur_ok = 1'b1;
          rsp_k  = 0;
          rsp_ops++;
        end
      end
      if (cur_ok) begin
        chk("resp_valid", 64'(resp_valid), 64'(NREQ'(1) << cur.w));
        chk("resp_data", 64'(resp_data), 64'(wordval(cur.w, cur.op, rsp_k)));
        rsp_k++;
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
  } vec_t;
  vec_t tbl [NT];

  int unsigned exp_op [NREQ];
  int unsigned w, op, prev_w, prev_op;
  logic        prev_busy;

  initial begin
    tbl[0]  = '{4'b0100, 4'b0100};
    tbl[1]  = '{4'b0000, 4'b0000};
    tbl[2]  = '{4'b1111, 4'b1000};
    tbl[3]  = '{4'b1111, 4'b0001};
    tbl[4]  = '{4'b1111, 4'b0010};
    tbl[5]  = '{4'b1111, 4'b0100};
    tbl[6]  = '{4'b1111, 4'b1000};
    tbl[7]  = '{4'b1111, 4'b0001};
    tbl[8]  = '{4'b0001, 4'b0000};
    tbl[9]  = '{4'b0001, 4'b0001};
    tbl[10] = '{4'b1010, 4'b0010};
    tbl[11] = '{4'b1010, 4'b1000};
    tbl[12] = '{4'b1010, 4'b0010};
    tbl[13] = '{4'b1010, 4'b1000};
    tbl[14] = '{4'b0100, 4'b0100};
    tbl[15] = '{4'b0000, 4'b0000};
    tbl[16] = '{4'b0000, 4'b0000};
    for (int unsigned i = 0; i < NREQ; i++) exp_op[i] = 0;

    rstn      = 1'b0;
    req       = '0;
    loop_en   = 1'b1;
    man_data  = '0;
    man_start = 1'b0;
    man_valid = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_unit_in", 64'(unit_in), 64'(0));
    chk("rst_unit_in_start", 64'(unit_in_start), 64'(0));
    chk("rst_unit_in_valid", 64'(unit_in_valid), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_resp_start", 64'(resp_start), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rstn   = 1'b1;
    mon_en = 1'b1;
    tick();

    // Arbitration table: one record per arbitration cycle.
    prev_busy = 1'b0;
    prev_w    = 0;
    prev_op   = 0;
    for (int unsigned e = 0; e < NT; e++) begin
      req = tbl[e].req;
      tick();
      chk("gnt_first", 64'(gnt), 64'(tbl[e].gnt));
      chk("uin_valid_edge", 64'(unit_in_valid), 64'(prev_busy));
      if (prev_busy) chk("uin_last_word", 64'(unit_in), 64'(wordval(prev_w, prev_op, NW - 1)));
      if (tbl[e].gnt != '0) begin
        w  = oh2idx(tbl[e].gnt);
        op = exp_op[w];
        sbq.push_back('{w, op});
        granted++;
        for (int unsigned j = 1; j < NW; j++) begin
          tick();
          chk("gnt_hold", 64'(gnt), 64'(tbl[e].gnt));
          chk("uin_valid", 64'(unit_in_valid), 64'(1));
          chk("uin_start", 64'(unit_in_start), 64'(j == 1));
          chk("uin_word", 64'(unit_in), 64'(wordval(w, op, j - 1)));
        end
        prev_busy = 1'b1;
        prev_w    = w;
        prev_op   = op;
        exp_op[w]++;
      end else begin
        prev_busy = 1'b0;
      end
    end
    req = '0;
    repeat (25) tick();
    chk("resp_ops", 64'(rsp_ops), 64'(granted));
    chk("sb_empty", 64'(sbq.size()), 64'(0));
    chk("err_clean", 64'(err), 64'(0));

    // Results withheld with MAXINFL=2: the third grant waits for the first result start.
    mon_en  = 1'b0;
    loop_en = 1'b0;
    req     = 4'b0011;
    tick();
    chk("stall_g1", 64'(gnt), 64'(4'b0001));
    repeat (NW) tick();
    chk("stall_g2", 64'(gnt), 64'(4'b0010));
    repeat (NW) tick();
    chk("stall_hold", 64'(gnt), 64'(0));
    repeat (3) tick();
    chk("stall_hold_late", 64'(gnt), 64'(0));
    chk("stall_err", 64'(err), 64'(0));
    man_data  = 34'h2_AAAA_5555;
    man_start = 1'b1;
    man_valid = 1'b1;
    tick();
    chk("stall_release", 64'(gnt), 64'(4'b0001));
    chk("pop1_valid", 64'(resp_valid), 64'(4'b0001));
    chk("pop1_data", 64'(resp_data), 64'(34'h2_AAAA_5555));
    chk("pop1_start", 64'(resp_start), 64'(1));
    req = '0;
    tick();
    chk("pop2_valid", 64'(resp_valid), 64'(4'b0010));
    tick();
    chk("pop3_valid", 64'(resp_valid), 64'(4'b0001));
    chk("pre_spurious_err", 64'(err), 64'(0));
    tick();
    chk("spurious_err", 64'(err), 64'(1));
    chk("spurious_drop", 64'(resp_valid), 64'(0));
    man_start = 1'b0;
    man_valid = 1'b0;
    repeat (10) tick();
    chk("err_sticky", 64'(err), 64'(1));
    chk("idle_after", 64'(gnt), 64'(0));

    // Reset mid-slot at cnt==4.
    req = 4'b0100;
    tick();
    chk("rs_gnt", 64'(gnt), 64'(4'b0100));
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    chk("rs_gnt_off", 64'(gnt), 64'(0));
    chk("rs_uin_valid", 64'(unit_in_valid), 64'(0));
    chk("rs_err_clr", 64'(err), 64'(0));
    rstn      = 1'b1;
    req       = '0;
    man_start = 1'b1;
    man_valid = 1'b1;
    tick();
    chk("rs_fifo_flushed", 64'(err), 64'(1));
    chk("rs_no_resp", 64'(resp_valid), 64'(0));
    man_start = 1'b0;
    man_valid = 1'b0;
    rstn      = 1'b0;
    tick();
    rstn = 1'b1;
    req  = 4'b1111;
    tick();
    chk("rs_first_winner", 64'(gnt), 64'(4'b0001));
    chk("rs_err_after", 64'(err), 64'(0));
    req = '0;
    repeat (NW + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accelbrot_com_arb.md
# accelbrot_com_arb

Round-robin arbiter that shares one word-serial arithmetic unit (abs, inverter, adder, …) between `NREQ` requesters. Operands travel as `NWORDS` words of `WWIDTH` bits, least-significant word first, with `start` marking the first word. The arbiter grants whole-operand slots, muxes the granted stream into the shared unit and tags each operand. It then steers the unit's results back to the originating requester, so several pixel engines can share one costly arithmetic unit without changing their serial framing.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `NWORDS`, 8: words per operand, ≥2.
- `WWIDTH`, 34: word width.
- `MAXINFL`, 4: max operands in flight inside the shared unit; tag FIFO depth.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `req`  in  NREQ  request per requester; held until first `gnt` cycle.
- `req_data`  in  NREQ*WWIDTH  word from requester i at bits [i*WWIDTH +: WWIDTH].
- `gnt`  out  NREQ  one-hot; high for exactly `NWORDS` consecutive cycles per slot; requester drives word k on the k-th `gnt` cycle.
- `unit_in`  out  WWIDTH  word to the shared unit.
- `unit_in_start`  out  1  first word of operand.
- `unit_in_valid`  out  1  word valid.
- `unit_out`  in  WWIDTH  result word from the shared unit.
- `unit_out_start`  in  1  first result word.
- `unit_out_valid`  in  1  result word valid.
- `resp_data`  out  WWIDTH  result word, broadcast to all requesters.
- `resp_start`  out  1  first result word.
- `resp_valid`  out  NREQ  one-hot: result word belongs to requester i.
- `err`  out  1  sticky protocol error.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: word counter `cnt` runs 0..NWORDS-1.
- Arbitration:
  - Performed in IDLE, and in BUSY at `cnt==NWORDS-1`.
  - Candidates: `req` bits, excluding the requester currently granted at its last cycle.
  - Search is round-robin starting at `ptr+1` mod NREQ.
  - A grant is issued only if FIFO occupancy (after this cycle's pop) is below `MAXINFL`.
- On a winner:
  - `gnt` becomes one-hot for the next `NWORDS` cycles, `ptr` ← winner, and the tag is pushed into the FIFO.
  - A new slot may follow the previous one directly, with no idle cycle between them.
- With no winner, the FSM enters or stays in IDLE and `gnt` becomes 0.
- A `req` that drops mid-slot does not shorten the slot.
- `unit_in`, `unit_in_start` and `unit_in_valid` are registered:
  - `unit_in` = `req_data` word of the granted requester.
  - `unit_in_start` = (`cnt==0`).
  - `unit_in_valid` = any `gnt`.
- Returned results:
  - On `unit_out_valid && unit_out_start`, the head tag is popped and latched as `cur_tag`.
  - Following valid words reuse `cur_tag`.
  - `resp_data` and `resp_start` are registered copies of the unit outputs.
  - `resp_valid` = one-hot(tag) & `unit_out_valid`, registered.
- `err` is set by either condition:
  - `unit_out_start` arrives with the FIFO empty; the result is dropped and `resp_valid` = 0.
  - A FIFO push happens while the FIFO is full, which is unreachable by design and is treated as an assertion.
- `err` is cleared only by reset.

## Timing
- Reset values:
  - Outputs: `gnt`=0, `unit_in`=0, `unit_in_start`=0, `unit_in_valid`=0, `resp_data`=0, `resp_start`=0, `resp_valid`=0, `err`=0.
  - Internal: FSM=IDLE, `cnt`=0, `ptr`=NREQ-1 (requester 0 wins first), FIFO empty.
- Latencies:
  - `req` high in IDLE at cycle t gives `gnt` at t+1..t+NWORDS.
  - The requester's word at `gnt` cycle c appears on `unit_in` at c+1.
  - `unit_out` at cycle u appears on `resp_*` at u+1.
- Reset asserted mid-slot aborts the slot immediately and flushes the tags. The shared unit must be reset by the same `rstn`, so no orphan results return.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.

## Structure
- Shared package `accelbrot_com_pkg`:
  - Tag width constant: `$clog2(NREQ)`, minimum 1.
  - FSM state enum `arb_state_t` {IDLE, BUSY}.
  - Function for round-robin one-hot pick.
- Sub-module `accelbrot_com_tag_fifo`:
  - Synchronous FIFO with depth `MAXINFL` and width equal to the tag width.
  - Ports: push, pop, data in/out, empty, full, count.

## Test plan
- Single request, NWORDS=8: `req[2]`=1 at cycle 10 → `gnt[2]` high for cycles 11–18; `unit_in_start` at 12; words on `unit_in` at 12–19 match the requester's words 0..7.
- All four `req` held high → grants rotate 0,1,2,3,0 with no gap: each slot is 8 cycles and `unit_in_valid` is continuously 1.
- Loopback unit with 8-cycle latency, requesters 1 and 3 alternating → `resp_valid[1]` and `resp_valid[3]` each carry their own operand, bit-exact, with `resp_start` on the first word.
- Slow unit, `MAXINFL`=2 and results withheld → third grant is stalled until the first `unit_out_start` is seen, then issued in the following arbitration cycle.
- Spurious `unit_out_start` with the FIFO empty → `err`=1 and stays 1; `resp_valid`=0.
- `rstn`=0 at `cnt`=4 of a slot → the next cycle shows `gnt`=0, `unit_in_valid`=0 and the FIFO empty; after release, requester 0 wins first.
